// File: rtl/stream_pkg.sv
// Shared definitions for the stream transmit path: byte width and hold-FSM state encodings.
// The GAP state exists only when STREAM_HOLD_TX_GAP_EN is defined.
package stream_pkg;

  localparam int unsigned STREAM_DW = 8;

`ifdef STREAM_HOLD_TX_GAP_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1
  } state_t;
`endif

endpackage

// File: rtl/stream_fifo.sv
// Synchronous FIFO with show-ahead read data; pointers carry an extra MSB
// so full and empty are distinguished from registered state alone.
module stream_fifo #(
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned WIDTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W:0]  wr_ptr;
  logic [ADDR_W:0]  rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[ADDR_W-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign level   = wr_ptr - rd_ptr;

endmodule

// File: rtl/stream_hold_tx.sv
// Buffers upstream bytes and presents each one with valid_out high for HOLD_CYCLES cycles.
// Define STREAM_HOLD_TX_GAP_EN to insert one valid-low GAP cycle after every byte.
module stream_hold_tx
  import stream_pkg::*;
#(
  parameter int unsigned ADDR_W      = 2,
  parameter int unsigned HOLD_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [STREAM_DW-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [STREAM_DW-1:0] data_out,
  output logic                 valid_out,
  output logic [ADDR_W:0]      fifo_level,
  output logic                 busy
);

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  state_t               state_q, state_d;
  logic [3:0]           hold_q, hold_d;
  logic [STREAM_DW-1:0] data_q, data_d;
  logic                 valid_q, valid_d;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [STREAM_DW-1:0] fifo_rd_data;
  logic                 wr_en;
  logic                 pop;
  logic                 load;

  assign in_ready = !fifo_full && !rst;
  assign wr_en    = in_valid && in_ready;

  stream_fifo #(
    .ADDR_W (ADDR_W),
    .WIDTH  (STREAM_DW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (in_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  // Every path that starts a new byte goes through 'load', so the pop,
  // data capture and counter clear happen in exactly one place.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    data_d  = data_q;
    valid_d = valid_q;
    pop     = 1'b0;
    load    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        load    = !fifo_empty;
      end
      ST_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          hold_d = '0;
`ifdef STREAM_HOLD_TX_GAP_EN
          state_d = ST_GAP;
          valid_d = 1'b0;
`else
          if (fifo_empty) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
          end else begin
            load = 1'b1;
          end
`endif
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
`ifdef STREAM_HOLD_TX_GAP_EN
      ST_GAP: begin
        valid_d = 1'b0;
        if (fifo_empty) state_d = ST_IDLE;
        else            load    = 1'b1;
      end
`endif
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase

    if (load) begin
      pop     = 1'b1;
      data_d  = fifo_rd_data;
      valid_d = 1'b1;
      hold_d  = '0;
      state_d = ST_HOLD;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign busy      = (state_q != ST_IDLE) || (fifo_level != '0);

endmodule

// File: tb/tb_stream_hold_tx.sv
// Directed testbench for stream_hold_tx; covers both default and STREAM_HOLD_TX_GAP_EN builds.
module tb_stream_hold_tx;

  localparam int H = 3;
`ifdef STREAM_HOLD_TX_GAP_EN
  localparam int GAPW = 1;
`else
  localparam int GAPW = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] data_out;
  logic       valid_out;
  logic [2:0] fifo_level;
  logic       busy;

  int checks = 0;
  int passed = 0;

  // downstream consumer: captures on its H-th consecutive valid cycle
  logic [7:0] capq[$];
  int         ccnt = 0;

  stream_hold_tx #(
    .ADDR_W      (2),
    .HOLD_CYCLES (H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .fifo_level (fifo_level),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    if (valid_out) begin
      ccnt++;
      if (ccnt == H) begin
        capq.push_back(data_out);
        ccnt = 0;
      end
    end else begin
      ccnt = 0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    step(); step();
    checks++; if (valid_out !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_out); else passed++;
    checks++; if (data_out !== 8'h00) $display("FAIL reset_data: got %h want 00", data_out); else passed++;
    checks++; if (fifo_level !== 3'd0) $display("FAIL reset_level: got %0d want 0", fifo_level); else passed++;
    checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL release_in_ready: got %b want 1", in_ready); else passed++;
    step();
  endtask

  task automatic test_single();
    capq.delete();
    in_data = 8'hA5; in_valid = 1'b1;
    checks++; if (in_ready !== 1'b1) $display("FAIL single_in_ready: got %b want 1", in_ready); else passed++;
    step();
    in_valid = 1'b0;
    checks++; if (fifo_level !== 3'd1) $display("FAIL single_level_n1: got %0d want 1", fifo_level); else passed++;
    checks++; if (valid_out !== 1'b0) $display("FAIL single_valid_n1: got %b want 0", valid_out); else passed++;
    step();
    for (int k = 0; k < H; k++) begin
      checks++; if (valid_out !== 1'b1) $display("FAIL single_valid_hold%0d: got %b want 1", k, valid_out); else passed++;
      checks++; if (data_out !== 8'hA5) $display("FAIL single_data_hold%0d: got %h want a5", k, data_out); else passed++;
      step();
    end
    checks++; if (valid_out !== 1'b0) $display("FAIL single_valid_end: got %b want 0", valid_out); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL single_busy_end: got %b want 0", busy); else passed++;
    step();
  endtask

  task automatic test_back_to_back();
    logic [7:0] b [3];
    int e, slot, ph;
    logic       ev;
    b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33;
    for (int k = 0; k <= 2 + 3 * (H + GAPW); k++) begin
      in_valid = (k < 3);
      in_data  = (k < 3) ? b[k] : 8'h00;
      if (k >= 2) begin
        e    = k - 2;
        slot = e / (H + GAPW);
        ph   = e % (H + GAPW);
        ev   = (slot < 3) && (ph < H);
        checks++; if (valid_out !== ev) $display("FAIL burst_valid_k%0d: got %b want %b", k, valid_out, ev); else passed++;
        if (ev) begin
          checks++; if (data_out !== b[slot]) $display("FAIL burst_data_k%0d: got %h want %h", k, data_out, b[slot]); else passed++;
        end
      end
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_full();
    int  idx = 0;
    int  peak = 0;
    logic wrote;
    capq.delete();
    for (int cyc = 0; cyc < 60; cyc++) begin
      in_valid = (idx < 6);
      in_data  = 8'hC0 + 8'(idx);
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
      if (fifo_level == 3'd4) begin
        checks++; if (in_ready !== 1'b0) $display("FAIL full_in_ready_c%0d: got %b want 0", cyc, in_ready); else passed++;
      end
      wrote = in_valid && in_ready;
      step();
      if (wrote) idx++;
    end
    in_valid = 1'b0;
    checks++; if (peak != 4) $display("FAIL full_peak: got %0d want 4", peak); else passed++;
    checks++; if (capq.size() != 6) $display("FAIL full_count: got %0d want 6", capq.size()); else passed++;
    for (int i = 0; i < 6 && i < capq.size(); i++) begin
      checks++; if (capq[i] !== 8'hC0 + 8'(i)) $display("FAIL full_order%0d: got %h want %h", i, capq[i], 8'hC0 + 8'(i)); else passed++;
    end
  endtask

  task automatic test_simul_wr_pop();
    logic [7:0] b [4];
    b[0] = 8'h41; b[1] = 8'h42; b[2] = 8'h43; b[3] = 8'h44;
    capq.delete();
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = b[k];
      step();
    end
    in_valid = 1'b0;
    repeat (1 + GAPW) step();
    checks++; if (fifo_level !== 3'd2) $display("FAIL simul_level_before: got %0d want 2", fifo_level); else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL simul_busy: got %b want 1", busy); else passed++;
    in_valid = 1'b1; in_data = b[3];
    step();
    in_valid = 1'b0;
    checks++; if (fifo_level !== 3'd2) $display("FAIL simul_level_after: got %0d want 2", fifo_level); else passed++;
    repeat (20) step();
    checks++; if (capq.size() != 4) $display("FAIL simul_count: got %0d want 4", capq.size()); else passed++;
    for (int i = 0; i < 4 && i < capq.size(); i++) begin
      checks++; if (capq[i] !== b[i]) $display("FAIL simul_order%0d: got %h want %h", i, capq[i], b[i]); else passed++;
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [7:0] b [5];
    logic       bad = 1'b0;
    b[0] = 8'h77; b[1] = 8'h5A; b[2] = 8'h61; b[3] = 8'h62; b[4] = 8'h63;
    capq.delete();
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_data = b[k];
      step();
    end
    in_valid = 1'b0;
    repeat (1 + GAPW) step();
    checks++; if (valid_out !== 1'b1 || data_out !== 8'h5A) $display("FAIL midrst_pre: got %b/%h want 1/5a", valid_out, data_out); else passed++;
    checks++; if (fifo_level !== 3'd3) $display("FAIL midrst_pre_level: got %0d want 3", fifo_level); else passed++;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (valid_out !== 1'b0) $display("FAIL midrst_valid: got %b want 0", valid_out); else passed++;
    checks++; if (data_out !== 8'h00) $display("FAIL midrst_data: got %h want 00", data_out); else passed++;
    checks++; if (fifo_level !== 3'd0) $display("FAIL midrst_level: got %0d want 0", fifo_level); else passed++;
    step();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (valid_out !== 1'b0 || fifo_level !== 3'd0 || busy !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) $display("FAIL midrst_quiet: got %b want 0", bad); else passed++;
    checks++; if (capq.size() != 1) $display("FAIL midrst_captures: got %0d want 1", capq.size()); else passed++;
  endtask

  task automatic test_downstream();
    int   idx = 0;
    logic wrote;
    capq.delete();
    for (int cyc = 0; cyc < 80; cyc++) begin
      in_valid = (idx < 8);
      in_data  = 8'(idx + 1);
      wrote    = in_valid && in_ready;
      step();
      if (wrote) idx++;
    end
    in_valid = 1'b0;
    checks++; if (capq.size() != 8) $display("FAIL down_count: got %0d want 8", capq.size()); else passed++;
    for (int i = 0; i < 8 && i < capq.size(); i++) begin
      checks++; if (capq[i] !== 8'(i + 1)) $display("FAIL down_order%0d: got %h want %h", i, capq[i], 8'(i + 1)); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_simul_wr_pop();
    test_reset_mid_hold();
    test_downstream();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
